// File: rtl/score_pkg.sv
// Shared definitions for the pinball scoring engine.
//   - game state codes driven by the game controller
//   - default hole masks and base points for the eight standard groups
//   - sat_add: unsigned add clamped to an all-ones value of a given width
package score_pkg;

    // Game state codes
    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_GET   = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    // Group g occupies bits [g*8 +: 8] in both tables
    localparam logic [63:0] DEFAULT_GROUP_MASKS  = 64'h0448_92AA_2012_4955;
    localparam logic [63:0] DEFAULT_GROUP_POINTS = 64'h1008_0402_1008_0402;

    // Returns min(a + b, 2^width - 1). The sum is formed one bit wider than
    // the operands so it can never wrap before the clamp. width must be < 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/score_combo_tracker.sv
// Consecutive-match counter with idle timeout.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        synchronous clear of combo and timeout counter (game reset/over)
//   hit_event    a scored hit resolves this cycle
//   match        that hit matched the active group (valid with hit_event)
//   combo        current consecutive-match count, saturating at COMBO_MAX
module combo_tracker #(
    parameter int COMBO_MAX     = 3,
    parameter int COMBO_TIMEOUT = 1000,
    localparam int COMBO_W      = $clog2(COMBO_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               hit_event,
    input  logic               match,
    output logic [COMBO_W-1:0] combo
);

    localparam int TO_W = $clog2(COMBO_TIMEOUT);

    logic [TO_W-1:0] idle_cnt;

    // Priority: clear, then a resolving hit, then the idle timeout. The
    // counter only runs while a combo is live, so the drop happens exactly
    // COMBO_TIMEOUT edges after the last hit resolved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            combo    <= '0;
            idle_cnt <= '0;
        end else if (clear) begin
            combo    <= '0;
            idle_cnt <= '0;
        end else if (hit_event) begin
            idle_cnt <= '0;
            if (!match)
                combo <= '0;
            else if (combo != COMBO_W'(COMBO_MAX))
                combo <= combo + COMBO_W'(1);
        end else if (combo != '0) begin
            if (idle_cnt == TO_W'(COMBO_TIMEOUT - 1)) begin
                combo    <= '0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end
        end else begin
            idle_cnt <= '0;
        end
    end

endmodule

// File: rtl/score_engine.sv
// Pinball scoring engine: two-stage pipeline that matches hole hits against
// the selected group and adds a combo-multiplied award to a saturating score.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   state           game state code (see score_pkg)
//   selected_group  active scoring group
//   hit_valid       one-cycle pulse qualifying getball
//   getball         holes hit this cycle
//   score           current game score (saturating)
//   high_score      best score since rst, captured while in OVER
//   combo           consecutive-match count
//   add_valid       one-cycle pulse when an award lands on score
//   last_add        award applied at the last add_valid
module score_engine
    import score_pkg::*;
#(
    parameter int NUM_HOLES     = 8,
    parameter int NUM_GROUPS    = 8,
    parameter int PTS_W         = 8,
    parameter int SCORE_W       = 15,
    parameter int COMBO_MAX     = 3,
    parameter int COMBO_TIMEOUT = 1000,
    parameter logic [NUM_GROUPS*NUM_HOLES-1:0] GROUP_MASKS  = DEFAULT_GROUP_MASKS,
    parameter logic [NUM_GROUPS*PTS_W-1:0]     GROUP_POINTS = DEFAULT_GROUP_POINTS,
    localparam int GROUP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
    localparam int COMBO_W = $clog2(COMBO_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           state,
    input  logic [GROUP_W-1:0]   selected_group,
    input  logic                 hit_valid,
    input  logic [NUM_HOLES-1:0] getball,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   high_score,
    output logic [COMBO_W-1:0]   combo,
    output logic                 add_valid,
    output logic [SCORE_W-1:0]   last_add
);

    localparam int AWARD_W = PTS_W + COMBO_W;

    logic                 hit_ok;
    logic                 clear_game;
    logic [NUM_HOLES-1:0] group_mask;
    logic [PTS_W-1:0]     group_pts;

    logic                 s1_valid;
    logic                 s1_match;
    logic [PTS_W-1:0]     s1_pts;

    logic                 s2_event;
    logic                 s2_match;
    logic [COMBO_W:0]     mult;
    logic [AWARD_W-1:0]   award_full;
    logic [SCORE_W-1:0]   award_sat;
    logic [SCORE_W-1:0]   new_score;

    assign hit_ok     = hit_valid && (state == ST_GET);
    assign clear_game = (state == ST_RESET) || (state == ST_OVER);

    // Group lookup by comparison so an out-of-range group yields an empty
    // mask (never a match) instead of an out-of-bounds part-select.
    always_comb begin
        group_mask = '0;
        group_pts  = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (selected_group == GROUP_W'(g)) begin
                group_mask = GROUP_MASKS[g*NUM_HOLES +: NUM_HOLES];
                group_pts  = GROUP_POINTS[g*PTS_W +: PTS_W];
            end
        end
    end

    // Stage 1: register the accepted hit and its match result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_match <= 1'b0;
            s1_pts   <= '0;
        end else if (clear_game) begin
            s1_valid <= 1'b0;
            s1_match <= 1'b0;
            s1_pts   <= '0;
        end else begin
            s1_valid <= hit_ok;
            s1_match <= hit_ok && (|(getball & group_mask));
            s1_pts   <= hit_ok ? group_pts : '0;
        end
    end

    // Stage 2: an in-flight hit is dropped when the game is cleared
    assign s2_event = s1_valid && !clear_game;
    assign s2_match = s2_event && s1_match;

    // combo+1 needs one bit more than combo (COMBO_MAX+1 may be a power of 2);
    // the product still fits PTS_W+COMBO_W bits since combo+1 <= 2^COMBO_W.
    assign mult       = {1'b0, combo} + {{COMBO_W{1'b0}}, 1'b1};
    assign award_full = AWARD_W'(s1_pts) * AWARD_W'(mult);
    assign award_sat  = SCORE_W'(sat_add(32'd0, 32'(award_full), SCORE_W));
    assign new_score  = SCORE_W'(sat_add(32'(score), 32'(award_sat), SCORE_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score      <= '0;
            high_score <= '0;
            add_valid  <= 1'b0;
            last_add   <= '0;
        end else begin
            add_valid <= 1'b0;
            if (state == ST_RESET) begin
                score    <= '0;
                last_add <= '0;
            end else if (state == ST_OVER) begin
                // Compare against the score before this cycle's clear
                if (score > high_score)
                    high_score <= score;
                score <= '0;
            end else if (s2_match) begin
                score     <= new_score;
                last_add  <= award_sat;
                add_valid <= 1'b1;
            end
        end
    end

    combo_tracker #(
        .COMBO_MAX     (COMBO_MAX),
        .COMBO_TIMEOUT (COMBO_TIMEOUT)
    ) u_combo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_game),
        .hit_event (s2_event),
        .match     (s1_match),
        .combo     (combo)
    );

endmodule

// File: tb/tb_score_engine.sv
// Directed bench for score_engine: a vector table of isolated hits plus
// hand-written sequences for back-to-back hits, game over / high score,
// asynchronous reset, combo timeout and score saturation.
module tb_score_engine;
    import score_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state = ST_RESET;
    logic [2:0] selected_group = 3'd0;
    logic       hit_valid = 1'b0;
    logic [7:0] getball = 8'h00;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic [14:0] score, high_score, last_add;
    logic [1:0]  combo;
    logic        add_valid;

    // Short-timeout instance
    logic [14:0] t_score, t_high_score, t_last_add;
    logic [1:0]  t_combo;
    logic        t_add_valid;

    // Narrow-score instance
    logic [5:0]  s_score, s_high_score, s_last_add;
    logic [1:0]  s_combo;
    logic        s_add_valid;

    score_engine dut (
        .clk(clk), .rst(rst), .state(state), .selected_group(selected_group),
        .hit_valid(hit_valid), .getball(getball), .score(score),
        .high_score(high_score), .combo(combo), .add_valid(add_valid),
        .last_add(last_add)
    );

    score_engine #(.COMBO_TIMEOUT(10)) dut_to (
        .clk(clk), .rst(rst), .state(state), .selected_group(selected_group),
        .hit_valid(hit_valid), .getball(getball), .score(t_score),
        .high_score(t_high_score), .combo(t_combo), .add_valid(t_add_valid),
        .last_add(t_last_add)
    );

    score_engine #(.SCORE_W(6)) dut_sat (
        .clk(clk), .rst(rst), .state(state), .selected_group(selected_group),
        .hit_valid(hit_valid), .getball(getball), .score(s_score),
        .high_score(s_high_score), .combo(s_combo), .add_valid(s_add_valid),
        .last_add(s_last_add)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one hit for a cycle, idle a cycle, return at the negedge after
    // the stage-2 edge so the award is observable.
    task automatic do_hit(input logic [2:0] st, input logic [2:0] grp,
                          input logic hv, input logic [7:0] gb);
        @(negedge clk);
        state = st; selected_group = grp; hit_valid = hv; getball = gb;
        @(negedge clk);
        hit_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; state = ST_RESET; hit_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; state = ST_GET;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] st;
        logic [2:0] grp;
        logic       hv;
        logic [7:0] gb;
        int         exp_score;
        int         exp_combo;
        int         exp_av;
        int         exp_last;
    } vec_t;

    vec_t vecs[12];

    int bb_score[6] = '{16, 48, 96, 160, 224, 224};
    int bb_last[6]  = '{16, 32, 48, 64, 64, 64};
    int bb_combo[6] = '{1, 2, 3, 3, 3, 3};
    int bb_av[6]    = '{1, 1, 1, 1, 1, 0};

    logic [2:0] sat_grp[12] = '{3, 1, 3, 1, 3, 1, 1, 1, 1, 1, 1, 1};
    logic [7:0] sat_gb[12]  = '{8'h20, 8'h80, 8'h20, 8'h80, 8'h20, 8'h80,
                                8'h01, 8'h80, 8'h01, 8'h80, 8'h01, 8'h80};
    int sat_last[3] = '{32, 48, 63};

    initial begin
        vecs[0]  = '{ST_GET,  3'd0, 1'b1, 8'h01,  2, 1, 1,  2};
        vecs[1]  = '{ST_GET,  3'd1, 1'b1, 8'h80,  2, 0, 0,  2};
        vecs[2]  = '{ST_GET,  3'd1, 1'b1, 8'h01,  6, 1, 1,  4};
        vecs[3]  = '{ST_GET,  3'd2, 1'b1, 8'h10, 22, 2, 1, 16};
        vecs[4]  = '{ST_GET,  3'd4, 1'b1, 8'h0F, 28, 3, 1,  6};
        vecs[5]  = '{ST_GET,  3'd5, 1'b1, 8'h80, 44, 3, 1, 16};
        vecs[6]  = '{ST_GET,  3'd7, 1'b1, 8'hFB, 44, 0, 0, 16};
        vecs[7]  = '{ST_GET,  3'd6, 1'b1, 8'h40, 52, 1, 1,  8};
        vecs[8]  = '{ST_GET,  3'd0, 1'b0, 8'h01, 52, 1, 0,  8};
        vecs[9]  = '{ST_WAIT, 3'd0, 1'b1, 8'h01, 52, 1, 0,  8};
        vecs[10] = '{ST_GET,  3'd3, 1'b1, 8'h20, 84, 2, 1, 32};
        vecs[11] = '{ST_GET,  3'd2, 1'b1, 8'h00, 84, 0, 0, 32};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_score", 32'(score), 0);
        check("rst_high", 32'(high_score), 0);
        check("rst_combo", 32'(combo), 0);
        check("rst_add_valid", 32'(add_valid), 0);
        check("rst_last_add", 32'(last_add), 0);
        rst = 1'b0; state = ST_GET;

        // Isolated hits
        for (int i = 0; i < 12; i++) begin
            do_hit(vecs[i].st, vecs[i].grp, vecs[i].hv, vecs[i].gb);
            check($sformatf("vec%0d_score", i), 32'(score), vecs[i].exp_score);
            check($sformatf("vec%0d_combo", i), 32'(combo), vecs[i].exp_combo);
            check($sformatf("vec%0d_add_valid", i), 32'(add_valid), vecs[i].exp_av);
            check($sformatf("vec%0d_last_add", i), 32'(last_add), vecs[i].exp_last);
        end

        // Back-to-back hits on group 3, combo saturating
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check($sformatf("b2b%0d_score", k - 2), 32'(score), bb_score[k-2]);
                check($sformatf("b2b%0d_last_add", k - 2), 32'(last_add), bb_last[k-2]);
                check($sformatf("b2b%0d_combo", k - 2), 32'(combo), bb_combo[k-2]);
                check($sformatf("b2b%0d_add_valid", k - 2), 32'(add_valid), bb_av[k-2]);
            end
            selected_group = 3'd3; getball = 8'h20;
            hit_valid = (k < 5);
        end
        hit_valid = 1'b0;

        // Game over / high score
        do_reset();
        do_hit(ST_GET, 3'd3, 1'b1, 8'h20);
        do_hit(ST_GET, 3'd1, 1'b1, 8'h80);
        do_hit(ST_GET, 3'd3, 1'b1, 8'h20);
        do_hit(ST_GET, 3'd1, 1'b1, 8'h80);
        do_hit(ST_GET, 3'd2, 1'b1, 8'h10);
        check("game1_score", 32'(score), 40);
        @(negedge clk); state = ST_OVER;
        @(negedge clk);
        check("over1_high", 32'(high_score), 40);
        check("over1_score", 32'(score), 0);
        check("over1_combo", 32'(combo), 0);
        do_hit(ST_GET, 3'd3, 1'b1, 8'h20);
        do_hit(ST_GET, 3'd1, 1'b1, 8'h80);
        do_hit(ST_GET, 3'd1, 1'b1, 8'h01);
        check("game2_score", 32'(score), 20);
        @(negedge clk); state = ST_OVER;
        @(negedge clk);
        check("over2_high", 32'(high_score), 40);
        check("over2_score", 32'(score), 0);
        state = ST_RESET;
        @(negedge clk);
        @(negedge clk);
        check("stRESET_high", 32'(high_score), 40);
        check("stRESET_last_add", 32'(last_add), 0);

        // Asynchronous reset with a hit in flight
        do_hit(ST_GET, 3'd0, 1'b1, 8'h01);
        check("pre_rst_score", 32'(score), 2);
        @(negedge clk);
        hit_valid = 1'b1; selected_group = 3'd0; getball = 8'h01;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_score", 32'(score), 0);
        check("arst_high", 32'(high_score), 0);
        check("arst_combo", 32'(combo), 0);
        check("arst_last_add", 32'(last_add), 0);
        @(negedge clk);
        rst = 1'b0; hit_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("arst_after%0d_add_valid", k), 32'(add_valid), 0);
            check($sformatf("arst_after%0d_score", k), 32'(score), 0);
        end

        // Combo timeout (COMBO_TIMEOUT=10 instance)
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k <= 12; k++) begin
                @(negedge clk);
                if (r == 0 && k == 2) begin
                    check("to0_score", 32'(t_score), 2);
                    check("to0_combo_live", 32'(t_combo), 1);
                end
                if (r == 0 && k == 11) check("to0_combo_before", 32'(t_combo), 1);
                if (r == 0 && k == 12) check("to0_combo_expired", 32'(t_combo), 0);
                if (r == 1 && k == 2) check("to1_score", 32'(t_score), 4);
                if (r == 1 && k == 11) check("to1_combo_before", 32'(t_combo), 1);
                if (r == 1 && k == 12) begin
                    check("to1_combo_kept", 32'(t_combo), 2);
                    check("to1_score_mult2", 32'(t_score), 8);
                    check("to1_last_add", 32'(t_last_add), 4);
                    check("to1_add_valid", 32'(t_add_valid), 1);
                end
                selected_group = 3'd0; getball = 8'h01;
                hit_valid = (k == 0) || (r == 1 && k == 10);
            end
        end
        hit_valid = 1'b0;

        // Saturation (SCORE_W=6 instance)
        do_reset();
        for (int i = 0; i < 12; i++) do_hit(ST_GET, sat_grp[i], 1'b1, sat_gb[i]);
        check("sat_pre_score", 32'(s_score), 60);
        check("sat_pre_combo", 32'(s_combo), 0);
        do_hit(ST_GET, 3'd3, 1'b1, 8'h20);
        check("sat_score", 32'(s_score), 63);
        check("sat_last_add", 32'(s_last_add), 16);
        check("sat_add_valid", 32'(s_add_valid), 1);
        for (int i = 0; i < 3; i++) begin
            do_hit(ST_GET, 3'd3, 1'b1, 8'h20);
            check($sformatf("sat_award%0d_last_add", i), 32'(s_last_add), sat_last[i]);
            check($sformatf("sat_award%0d_score", i), 32'(s_score), 63);
        end
        check("sat_combo_max", 32'(s_combo), 3);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/score_engine.md
Name: score_engine

Overview:
Parametrised pinball scoring engine and successor to the fixed 8-hole/8-group scorer. It accepts hit events from the hole sensors and checks them against the currently selected scoring group. Matching hits add a combo-multiplied award to a saturating score. It also holds a high score across games and reports every award to the display/sound logic.

Parameters:
NUM_HOLES, 8, number of hole sensors (width of getball)
NUM_GROUPS, 8, number of scoring groups; GROUP_W = $clog2(NUM_GROUPS)
PTS_W, 8, width of base points per group
SCORE_W, 15, width of score and high_score
COMBO_MAX, 3, combo counter saturation value; multiplier = combo+1
COMBO_TIMEOUT, 1000, idle cycles after which a non-zero combo drops to 0 (must be >= 2)
GROUP_MASKS, 64'h0448_92AA_2012_4955, packed hole masks, group g at bits [g*NUM_HOLES +: NUM_HOLES]
GROUP_POINTS, 64'h1008_0402_1008_0402, packed base points, group g at bits [g*PTS_W +: PTS_W]

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
state  in  3  game state: RESET=0, WAIT=1, START=2, GET=3, OVER=4
selected_group  in  GROUP_W  active scoring group
hit_valid  in  1  one-cycle pulse: getball is valid
getball  in  NUM_HOLES  one-hot/multi-hot holes hit
score  out  SCORE_W  current game score
high_score  out  SCORE_W  best score since rst
combo  out  $clog2(COMBO_MAX+1)  current consecutive-match count
add_valid  out  1  one-cycle pulse: score just received an award
last_add  out  SCORE_W  award applied at the last add_valid

Behaviour:
- rst asserted: all outputs, pipeline and timeout counter go to 0 immediately.
- Stage 1, edge E: a hit is accepted when hit_valid=1 and state==GET. Register s1_valid, s1_match = |(getball & mask[selected_group]), s1_pts = points[selected_group]. Out-of-range selected_group (>= NUM_GROUPS) gives match=0.
- Stage 2, edge E+1: when s1_valid is set:
  - match: award = s1_pts*(combo+1); score <= min(score+award, 2^SCORE_W-1); last_add <= award (saturated to SCORE_W); add_valid=1 for one cycle; combo <= min(combo+1, COMBO_MAX).
  - miss: combo <= 0, score unchanged, add_valid=0.
- Latency: the score change is visible 2 edges after the hit_valid cycle. Hits on back-to-back cycles are fully supported; each uses the combo left by the previous hit.
- Timeout: the counter clears on every stage-2 event. While combo!=0 and no stage-2 event occurs, it increments. On reaching COMBO_TIMEOUT-1, combo <= 0 and the counter clears. A stage-2 event in the same cycle takes priority and the timeout is ignored that cycle.
- state==RESET: score, combo, pipeline, timeout, last_add and add_valid clear. high_score is held.
- state==OVER, every cycle: high_score <= max(high_score, score), using the pre-clear score; score, combo and pipeline clear. An in-flight stage-1 hit is discarded.
- WAIT/START: score and combo hold. A stage-2 hit still completes if it was accepted in GET one cycle earlier. Timeout keeps running.
- Arithmetic: the award is computed in PTS_W+COMBO_W bits. The sum is computed in SCORE_W+1 bits before saturation, so there is no wrap-around.

Decomposition:
- score_pkg: state code localparams (RESET..OVER), default GROUP_MASKS/GROUP_POINTS constants, and a saturating-add function.
- Sub-module combo_tracker: owns the combo counter and timeout counter. Inputs are event/match/clear; output is combo.

Test Plan:
- Default params, group 0, state GET, hit getball=8'h01 at cycle 10 -> score=2 visible after edge 12, add_valid pulse, last_add=2, combo=1.
- Group 3, four matching hits with getball=8'h20 on consecutive cycles -> awards 16,32,48,64; score=160; combo saturates at 3; a fifth hit awards 64.
- Group 1, match then getball=8'h80 (miss) -> combo=0, score unchanged, no add_valid; next match awards 4.
- COMBO_TIMEOUT=10, one match, then idle -> combo drops to 0 exactly 10 cycles after the stage-2 edge; a hit landing on the expiry cycle keeps the combo and gets multiplier 2.
- SCORE_W=6, score=60, group 3 match -> score=63 (saturated), last_add=16.
- Game scores 40 -> OVER -> high_score=40, score=0; next game scores 20 -> OVER -> high_score stays 40; state RESET keeps 40; rst mid-hit (asynchronous) -> everything 0 and no add_valid.
